// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber KEM sequencer: FSM encoding, hash mode
// constants and the rank-derived ciphertext geometry.
package kyber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_PRE  = 3'd2,
    ST_ENC  = 3'd3,
    ST_POST = 3'd4,
    ST_FIN  = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic HASH_MODE_G   = 1'b0;  // pre-hash G()
  localparam logic HASH_MODE_KDF = 1'b1;  // post-hash KDF

  // Ciphertext compression widths for module rank k.
  function automatic int du(input int k);
    return (k == 4) ? 11 : 10;
  endfunction

  function automatic int dv(input int k);
    return (k == 4) ? 5 : 4;
  endfunction

  // Ciphertext length in bytes: k compressed polys u plus one compressed poly v.
  function automatic int ct_bytes(input int k);
    return k * 32 * du(k) + 32 * dv(k);
  endfunction

endpackage

// File: rtl/kyber_kem_ctrl_if.sv
// Engine-side handshake bundle: start/done pairs for the hash and IND-CPA
// engines, the G() K-half, and the re-encryption compare stream.
interface kyber_kem_ctrl_if #(
  parameter int CMP_W = 64
);
  logic             hash_start;
  logic             hash_mode;
  logic             hash_done;
  logic             enc_start;
  logic             enc_done;
  logic             dec_start;
  logic             dec_done;
  logic [255:0]     kr_hi;
  logic             cmp_valid;
  logic [CMP_W-1:0] cmp_a;
  logic [CMP_W-1:0] cmp_b;

  // Sequencer side.
  modport master (
    output hash_start, hash_mode, enc_start, dec_start,
    input  hash_done, enc_done, dec_done, kr_hi, cmp_valid, cmp_a, cmp_b
  );

  // Engine side.
  modport slave (
    input  hash_start, hash_mode, enc_start, dec_start,
    output hash_done, enc_done, dec_done, kr_hi, cmp_valid, cmp_a, cmp_b
  );
endinterface

// File: rtl/kyber_ct_cmp.sv
// Streaming ciphertext comparator: OR-accumulates word differences and counts
// words; a word past the expected count is itself a difference.
module kyber_ct_cmp #(
  parameter int CMP_W    = 64,
  parameter int CT_WORDS = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [CMP_W-1:0] i_a,
  input  logic [CMP_W-1:0] i_b,
  output logic             o_mismatch
);

  localparam int CNT_W = $clog2(CT_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CT_WORDS);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_diff;
  logic             w_diff_nxt;
  logic             w_take;
  logic             w_over;

  // Next accumulator values; o_mismatch already includes the word in flight so
  // a final word arriving together with enc_done is not lost.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_take     = i_en & i_valid;
    w_over     = (r_cnt == CNT_FULL);
    w_diff_nxt = r_diff | (w_take & ((|(i_a ^ i_b)) | w_over));
    w_cnt_nxt  = r_cnt;
    if (w_take && !w_over) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    o_mismatch = w_diff_nxt | (w_cnt_nxt != CNT_FULL);
  end

  // Accumulator registers, cleared on reset and on entry to the compare window.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt  <= '0;
      r_diff <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_diff <= w_diff_nxt;
    end
  end

endmodule

// File: rtl/kyber_kem_ctrl.sv
// Kyber KEM sequencer (Encaps and Fujisaki-Okamoto Decaps). Issues engine start
// pulses, latches Kr_hi from G(), and selects Kr_hi or z for the post-hash.
module kyber_kem_ctrl
  import kyber_pkg::*;
#(
  parameter int KYBER_K     = 2,
  parameter int CT_BYTES    = ct_bytes(KYBER_K),
  parameter int CMP_W       = 64,
  parameter int CT_WORDS    = CT_BYTES * 8 / CMP_W,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [255:0]     i_z,
  kyber_kem_ctrl_if.master bus,
  output logic [255:0]     o_post_key,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_reject,
  output logic             o_error,
  output logic [2:0]       o_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_enter;
  logic              w_accept;
  logic              w_wd_expire;
  logic              w_mismatch;
  logic              r_mode;
  logic [255:0]      r_kr_hi;
  logic              r_reject;
  logic              r_error;
  logic              r_done;
  logic              r_hash_start;
  logic              r_enc_start;
  logic              r_dec_start;
  logic [WD_W-1:0]   r_wdog;

  // Next-state: advance on the matching done; done wins over a same-cycle timeout.
  always_comb begin
    w_next      = r_state;
    w_accept    = (r_state == ST_IDLE) && i_start;
    w_wd_expire = (r_wdog == WD_LAST);
    unique case (r_state)
      ST_IDLE: if (i_start) w_next = i_mode ? ST_DEC : ST_PRE;
      ST_DEC:  if (bus.dec_done)  w_next = ST_PRE;
               else if (w_wd_expire) w_next = ST_ERR;
      ST_PRE:  if (bus.hash_done) w_next = ST_ENC;
               else if (w_wd_expire) w_next = ST_ERR;
      ST_ENC:  if (bus.enc_done)  w_next = ST_POST;
               else if (w_wd_expire) w_next = ST_ERR;
      ST_POST: if (bus.hash_done) w_next = ST_FIN;
               else if (w_wd_expire) w_next = ST_ERR;
      ST_FIN:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    w_enter = (w_next != r_state);
  end

  // State register plus one-shot start pulses registered on state entry, so each
  // pulse sits in the first cycle of its state and reset drops it immediately.
  // NOTE: reset is synchronous; it only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hash_start <= 1'b0;
      r_enc_start  <= 1'b0;
      r_dec_start  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_hash_start <= w_enter && (w_next == ST_PRE || w_next == ST_POST);
      r_enc_start  <= w_enter && (w_next == ST_ENC);
      r_dec_start  <= w_enter && (w_next == ST_DEC);
      // FIN shows done during FIN; a timeout shows it in the IDLE cycle after ERR.
      r_done       <= (w_enter && w_next == ST_FIN) || (r_state == ST_ERR);
    end
  end

  // Watchdog: restarts on every state entry, counts only while awaiting a done.
  always_ff @(posedge clk) begin
    if (rst || w_enter) begin
      r_wdog <= '0;
    end else if (r_state inside {ST_DEC, ST_PRE, ST_ENC, ST_POST}) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Operation context: mode, Kr_hi and sticky result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= 1'b0;
      r_kr_hi  <= '0;
      r_reject <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode   <= i_mode;
        r_reject <= 1'b0;
        r_error  <= 1'b0;
      end
      if (r_state == ST_PRE && bus.hash_done) begin
        r_kr_hi <= bus.kr_hi;
      end
      if (r_state == ST_ENC && bus.enc_done) begin
        r_reject <= r_mode & w_mismatch;
      end
      if (r_state == ST_ERR) begin
        r_error <= 1'b1;
      end
    end
  end

  kyber_ct_cmp #(
    .CMP_W    (CMP_W),
    .CT_WORDS (CT_WORDS)
  ) u_ct_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_enter && w_next == ST_ENC),
    .i_en       (r_state == ST_ENC && r_mode),
    .i_valid    (bus.cmp_valid),
    .i_a        (bus.cmp_a),
    .i_b        (bus.cmp_b),
    .o_mismatch (w_mismatch)
  );

  assign bus.hash_start = r_hash_start;
  assign bus.hash_mode  = (r_state == ST_POST) ? HASH_MODE_KDF : HASH_MODE_G;
  assign bus.enc_start  = r_enc_start;
  assign bus.dec_start  = r_dec_start;

  assign o_post_key = r_reject ? i_z : r_kr_hi;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_reject   = r_reject;
  assign o_error    = r_error;
  assign o_state    = r_state;

endmodule

// File: tb/tb_kyber_kem_ctrl.sv
// Directed bench for kyber_kem_ctrl: Encaps, Decaps accept/reject, compare
// length errors, watchdog timeout, reset abort and ignored stray inputs.
module tb_kyber_kem_ctrl;

  localparam logic [255:0] KR = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [255:0] Z  = 256'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_F00D;
  localparam int SEL_HASH = 0;
  localparam int SEL_ENC  = 1;
  localparam int SEL_DEC  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_mode;
  logic [255:0] o_post_key;
  logic         o_busy, o_done, o_reject, o_error;
  logic [2:0]   o_state;

  logic         wd_start, wd_mode;
  logic [255:0] wd_post_key;
  logic         wd_busy, wd_done, wd_reject, wd_error;
  logic [2:0]   wd_state;

  int n_assert = 0;
  int n_fail   = 0;

  kyber_kem_ctrl_if #(.CMP_W(64)) bus ();
  kyber_kem_ctrl_if #(.CMP_W(64)) wbus ();

  kyber_kem_ctrl #(.KYBER_K(2), .CMP_W(64)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_z(Z), .bus(bus),
    .o_post_key(o_post_key), .o_busy(o_busy), .o_done(o_done),
    .o_reject(o_reject), .o_error(o_error), .o_state(o_state)
  );

  kyber_kem_ctrl #(.KYBER_K(2), .CMP_W(64), .TIMEOUT_CYC(16)) dut_wd (
    .clk(clk), .rst(rst), .i_start(wd_start), .i_mode(wd_mode), .i_z(Z), .bus(wbus),
    .o_post_key(wd_post_key), .o_busy(wd_busy), .o_done(wd_done),
    .o_reject(wd_reject), .o_error(wd_error), .o_state(wd_state)
  );

  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #500us;
    $display("FAIL timeout: simulation time bound expired");
    $fatal(1, "bench time bound expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.dec_start, bus.enc_start, bus.hash_start, bus.hash_mode};
  endfunction

  function automatic logic [63:0] word(input int i);
    return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hA5A5_0000};
  endfunction

  task automatic set_done(input int sel, input logic v);
    case (sel)
      SEL_HASH: bus.hash_done = v;
      SEL_ENC:  bus.enc_done  = v;
      default:  bus.dec_done  = v;
    endcase
  endtask

  task automatic start_kem(input logic mode);
    i_mode  = mode;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Check state/pulses on entry, pulse gone next cycle, done 5 cycles after start.
  task automatic hand(input string tag, input logic [2:0] st, input logic [3:0] pls,
                      input int sel, input int dly);
    check({tag, " state"}, o_state, st);
    check({tag, " pulses"}, pulses(), pls);
    tick();
    check({tag, " one-shot"}, pulses() & 4'b1110, 4'b0000);
    repeat (dly - 2) tick();
    if (sel == SEL_HASH && st == 3'd2) bus.kr_hi = KR;
    set_done(sel, 1'b1);
    tick();
    set_done(sel, 1'b0);
    bus.kr_hi = ~KR;
  endtask

  task automatic run_kem(input string tag, input logic mode, input int nwords,
                         input int bad, input logic exp_rej);
    start_kem(mode);
    check({tag, " rej clr"}, o_reject, 1'b0);
    check({tag, " busy"}, o_busy, 1'b1);
    if (mode) hand({tag, " DEC"}, 3'd1, 4'b1000, SEL_DEC, 5);
    hand({tag, " PRE"}, 3'd2, 4'b0010, SEL_HASH, 5);
    check({tag, " ENC state"}, o_state, 3'd3);
    check({tag, " ENC pulses"}, pulses(), 4'b0100);
    for (int i = 0; i < nwords; i++) begin
      bus.cmp_valid = 1'b1;
      bus.cmp_a     = word(i);
      bus.cmp_b     = word(i) ^ ((i == bad) ? 64'd1 : 64'd0);
      tick();
      if (i == 0) check({tag, " ENC one-shot"}, pulses(), 4'b0000);
    end
    bus.cmp_valid = 1'b0;
    bus.enc_done  = 1'b1;
    tick();
    bus.enc_done  = 1'b0;
    check({tag, " reject"}, o_reject, exp_rej);
    check({tag, " post_key"}, o_post_key, exp_rej ? Z : KR);
    hand({tag, " POST"}, 3'd4, 4'b0011, SEL_HASH, 5);
    check({tag, " FIN state"}, o_state, 3'd5);
    check({tag, " FIN done"}, o_done, 1'b1);
    tick();
    check({tag, " idle state"}, o_state, 3'd0);
    check({tag, " done low"}, {o_done, o_busy, o_error}, 3'b000);
    check({tag, " reject held"}, o_reject, exp_rej);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_mode = 1'b0;
    wd_start = 1'b0; wd_mode = 1'b0;
    bus.hash_done = 1'b0; bus.enc_done = 1'b0; bus.dec_done = 1'b0;
    bus.kr_hi = ~KR; bus.cmp_valid = 1'b0; bus.cmp_a = '0; bus.cmp_b = '0;
    wbus.hash_done = 1'b0; wbus.enc_done = 1'b0; wbus.dec_done = 1'b0;
    wbus.kr_hi = KR; wbus.cmp_valid = 1'b0; wbus.cmp_a = '0; wbus.cmp_b = '0;
    repeat (3) tick();

    // Reset state
    check("reset state", o_state, 3'd0);
    check("reset pulses", pulses(), 4'b0000);
    check("reset flags", {o_busy, o_done, o_reject, o_error}, 4'b0000);
    check("reset post_key", o_post_key, '0);
    rst = 1'b0;
    tick();

    // 1. Encaps; mismatching compare words must be ignored
    run_kem("encaps", 1'b0, 4, 0, 1'b0);
    // 2. Decaps, all 96 words equal
    run_kem("decaps ok", 1'b1, 96, -1, 1'b0);
    // 3. Decaps, last word differs in bit 0
    run_kem("decaps bad95", 1'b1, 96, 95, 1'b1);
    // 4. Decaps with short and long compare streams
    run_kem("decaps 95w", 1'b1, 95, -1, 1'b1);
    run_kem("decaps 97w", 1'b1, 97, -1, 1'b1);

    // 6a. Reset mid-ENC with enc_done in the same cycle
    start_kem(1'b0);
    hand("abort PRE", 3'd2, 4'b0010, SEL_HASH, 5);
    check("abort in ENC", o_state, 3'd3);
    rst = 1'b1;
    bus.enc_done = 1'b1;
    tick();
    rst = 1'b0;
    bus.enc_done = 1'b0;
    check("abort state", o_state, 3'd0);
    check("abort pulses", pulses(), 4'b0000);
    check("abort flags", {o_busy, o_done, o_reject, o_error}, 4'b0000);
    check("abort post_key", o_post_key, '0);
    tick();
    check("abort no pending", pulses(), 4'b0000);

    // 6b. Spurious hash_done in IDLE
    bus.hash_done = 1'b1;
    tick();
    bus.hash_done = 1'b0;
    check("spurious state", o_state, 3'd0);
    check("spurious pulses", pulses(), 4'b0000);

    // 6c. Start (Decaps) while busy in an Encaps run is ignored
    start_kem(1'b0);
    check("busy-start PRE", o_state, 3'd2);
    i_start = 1'b1;
    i_mode  = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy-start state", o_state, 3'd2);
    check("busy-start pulses", pulses(), 4'b0000);
    repeat (2) tick();
    bus.kr_hi = KR;
    bus.hash_done = 1'b1;
    tick();
    bus.hash_done = 1'b0;
    bus.kr_hi = ~KR;
    check("busy-start ENC", o_state, 3'd3);
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    check("busy-start reject", o_reject, 1'b0);
    check("busy-start post_key", o_post_key, KR);
    bus.hash_done = 1'b1;
    tick();
    bus.hash_done = 1'b0;
    check("busy-start FIN", {o_state, o_done}, {3'd5, 1'b1});
    tick();

    // 5. Watchdog on the TIMEOUT_CYC=16 instance: enc_done never arrives
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    check("wd PRE", wd_state, 3'd2);
    repeat (4) tick();
    wbus.hash_done = 1'b1;
    tick();
    wbus.hash_done = 1'b0;
    check("wd ENC entry", wd_state, 3'd3);
    repeat (15) tick();
    check("wd ENC at +15", wd_state, 3'd3);
    tick();
    check("wd ERR at +16", wd_state, 3'd6);
    check("wd ERR flags", {wd_busy, wd_done, wd_error}, 3'b100);
    tick();
    check("wd idle", wd_state, 3'd0);
    check("wd done+error", {wd_busy, wd_done, wd_error}, 3'b011);
    tick();
    check("wd error held", {wd_done, wd_error}, 2'b01);
    wd_start = 1'b1;
    tick();
    wd_start = 1'b0;
    check("wd error cleared", {wd_state, wd_error}, {3'd2, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
